decode_ctrl_pipe: RTL and testbench
===================================

DECODE_CTRL_PIPE -- requirements
Module: decode_ctrl_pipe

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3, meaning multiply occupancy in cycles, legal range 1..15.
REQ-002 SHALL have parameter EN_MUL, default 1, meaning 1 decodes MUL and 0 flags MUL as illegal.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 flush  in  1  discard held and in-flight instruction.
REQ-006 in_valid / in_ready  in / out  1 / 1  fetch-side handshake.
REQ-007 instr  in  32  instruction word.
REQ-008 out_valid / out_ready  out / in  1 / 1  execute-side handshake.
REQ-009 Control bundle outputs, all registered:
- RegSrc  out  2
- ImmSrc  out  2
- ALUSrc  out  1
- MemtoReg  out  1
- RegW  out  1
- MemW  out  1
- Branch  out  1
- Link  out  1
- PCS  out  1
- FlagW  out  2
- ALUControl  out  3
- Mul  out  1
- Illegal  out  1
- Cond  out  4, equal to instr[31:28]

Function
REQ-010 Fields SHALL be Op=instr[27:26], Funct=instr[25:20], Rd=instr[15:12].
REQ-011 Decode of {RegSrc,ImmSrc,ALUSrc,MemtoReg,RegW,MemW,Branch} SHALL follow this table:
- DP-imm (Op=00, Funct[5]=1): 00,00,1,0,1,0,0
- DP-reg (Op=00, Funct[5]=0): 00,00,0,0,1,0,0
- LDR (Op=01, Funct[0]=1): 00,01,1,1,1,0,0
- STR (Op=01, Funct[0]=0): 10,01,1,1,0,1,0
- BL (Op=10, Funct[4]=1): 01,10,1,0,1,0,1, with Link=1
- B (Op=10, Funct[4]=0): 01,10,1,0,0,0,1
REQ-012 For DP, ALUControl SHALL be set from Funct[4:1]:
- 0100 ADD -> 000
- 0010 SUB -> 001
- 0000 AND -> 010
- 1100 ORR -> 011
- 1101 shift -> 100
- 0001 EOR -> 101
- any other Funct[4:1] -> Illegal=1
REQ-013 For non-DP instructions, ALUControl SHALL be 000 and FlagW SHALL be 00.
REQ-014 For DP, FlagW[1] SHALL equal Funct[0], and FlagW[0] SHALL equal Funct[0] AND (ALUControl is ADD or SUB).
REQ-015 MUL SHALL be recognised as Op=00, Funct[5:1]=00000, instr[7:4]=1001; it sets Mul=1, RegW=1, ALUSrc=0, and ALUControl=000.
REQ-016 PCS SHALL equal (Rd==1111) AND RegW.
REQ-017 Op=11 and any unlisted encoding SHALL set Illegal=1 with RegW, MemW, Branch, PCS and FlagW all forced to 0; no output is ever X.
REQ-018 FSM states: EMPTY, HOLD, MULW.
REQ-019 An accept SHALL occur when in_valid=1, in_ready=1 and flush=0.
REQ-020 in_ready SHALL be 1 in EMPTY, equal out_ready in HOLD, 0 in MULW, and 0 whenever flush=1.
REQ-021 From EMPTY or HOLD, an accepted non-MUL instruction SHALL go to HOLD with out_valid=1 on the next cycle (latency 1).
REQ-022 From EMPTY or HOLD, an accepted MUL SHALL go to MULW, load the counter with MUL_LAT-1, and hold out_valid=0.
REQ-023 MULW SHALL decrement the counter each cycle and go to HOLD when it reaches 0, so out_valid rises MUL_LAT cycles after the accept; for MUL_LAT=1 the transition is direct to HOLD.
REQ-024 In HOLD with out_ready=0, the bundle SHALL be stable and no new instruction is accepted.
REQ-025 In HOLD, an out_ready=1 cycle with an accept SHALL replace the bundle back-to-back (throughput 1/cycle); without an accept the state goes to EMPTY.
REQ-026 flush=1 in any state SHALL give EMPTY, out_valid=0 and counter=0 next cycle, with priority over accept and countdown.

Reset
REQ-027 reset=0 at a clock edge SHALL give: state EMPTY, counter 0, out_valid 0, and every bundle output 0 (Cond=0000).
REQ-028 While reset=0, in_ready SHALL be 0.
REQ-029 Reset mid-MULW SHALL abandon the multiply with no output.

Structure
REQ-030 A shared package SHALL hold: the FSM state enum, ALUControl codes (ADD..EOR), Op codes, and the packed control-bundle struct.
REQ-031 One sub-module, decode_ctrl_comb, SHALL be the purely combinational instr-to-bundle decoder; decode_ctrl_pipe holds the FSM, counter and output register.

Verification
REQ-032 ADDS r1 (instr 0xE0911002) accepted at cycle 0 -> cycle 1: out_valid=1, ALUControl=000, FlagW=11, RegW=1, PCS=0.
REQ-033 LDR pc (0xE591F000) -> MemtoReg=1, ImmSrc=01, PCS=1; with out_ready=0 for 3 cycles, bundle stable and in_ready=0.
REQ-034 MUL (0xE0010392), MUL_LAT=3 -> in_ready=0 for cycles 1-2, out_valid=1 at cycle 3, Mul=1; repeat with EN_MUL=0 -> Illegal=1 at cycle 1, RegW=0.
REQ-035 flush=1 asserted at cycle 1 of a MUL together with in_valid=1 -> cycle 2 EMPTY, out_valid=0, nothing accepted.
REQ-036 Stream of 4 DP instrs with out_ready=1 -> 4 outputs on consecutive cycles; Op=11 word -> Illegal=1, RegW=MemW=Branch=0.

Source files
------------

// File: rtl/decode_ctrl_pipe_pkg.sv
// Shared types for the decode/control pipeline stage: FSM states, ALU codes,
// opcode classes and the packed control bundle.
package decode_ctrl_pipe_pkg;

  typedef logic [1:0] state_t;
  localparam state_t StEmpty = 2'd0;
  localparam state_t StHold  = 2'd1;
  localparam state_t StMulw  = 2'd2;

  typedef logic [2:0] alu_t;
  localparam alu_t AluAdd   = 3'b000;
  localparam alu_t AluSub   = 3'b001;
  localparam alu_t AluAnd   = 3'b010;
  localparam alu_t AluOrr   = 3'b011;
  localparam alu_t AluShift = 3'b100;
  localparam alu_t AluEor   = 3'b101;

  localparam logic [1:0] OpDp    = 2'b00;
  localparam logic [1:0] OpMem   = 2'b01;
  localparam logic [1:0] OpBr    = 2'b10;
  localparam logic [1:0] OpUndef = 2'b11;

  localparam logic [3:0] MulTag = 4'b1001;

  typedef struct packed {
    logic [1:0] reg_src;
    logic [1:0] imm_src;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       link;
    logic       pcs;
    logic [1:0] flag_w;
    alu_t       alu_ctrl;
    logic       mul;
    logic       illegal;
    logic [3:0] cond;
  } ctrl_t;

endpackage

// File: rtl/decode_ctrl_comb.sv
// Purely combinational instruction-word to control-bundle decoder.
module decode_ctrl_comb
  import decode_ctrl_pipe_pkg::*;
#(
  parameter int unsigned EN_MUL = 1
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       mul_pat;
  logic       bad;
  logic       alu_ok;
  alu_t       alu;

  assign op      = instr[27:26];
  assign funct   = instr[25:20];
  assign rd      = instr[15:12];
  assign mul_pat = (op == OpDp) && (funct[5:1] == 5'b00000) && (instr[7:4] == MulTag);

  logic unused_bits;
  assign unused_bits = ^{instr[19:16], instr[11:8], instr[3:0]};

  always_comb begin
    alu    = AluAdd;
    alu_ok = 1'b1;
    case (funct[4:1])
      4'b0100: alu = AluAdd;
      4'b0010: alu = AluSub;
      4'b0000: alu = AluAnd;
      4'b1100: alu = AluOrr;
      4'b1101: alu = AluShift;
      4'b0001: alu = AluEor;
      default: alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    ctrl = '0;
    bad  = 1'b0;
    if (mul_pat) begin
      // MUL shares the DP opcode space, so it must be caught before the DP table.
      if (EN_MUL != 0) begin
        ctrl.reg_w  = 1'b1;
        ctrl.mul    = 1'b1;
        ctrl.flag_w = {funct[0], 1'b0};
      end else begin
        bad = 1'b1;
      end
    end else begin
      case (op)
        OpDp: begin
          if (alu_ok) begin
            ctrl.alu_src  = funct[5];
            ctrl.reg_w    = 1'b1;
            ctrl.alu_ctrl = alu;
            ctrl.flag_w   = {funct[0], funct[0] & ((alu == AluAdd) | (alu == AluSub))};
          end else begin
            bad = 1'b1;
          end
        end
        OpMem: begin
          ctrl.imm_src    = 2'b01;
          ctrl.alu_src    = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          if (funct[0]) begin
            ctrl.reg_w = 1'b1;
          end else begin
            ctrl.reg_src = 2'b10;
            ctrl.mem_w   = 1'b1;
          end
        end
        OpBr: begin
          ctrl.reg_src = 2'b01;
          ctrl.imm_src = 2'b10;
          ctrl.alu_src = 1'b1;
          ctrl.branch  = 1'b1;
          ctrl.reg_w   = funct[4];
          ctrl.link    = funct[4];
        end
        default: bad = 1'b1;
      endcase
    end
    // Illegal words produce a quiet bundle: nothing written, no branch, no flags.
    if (bad) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
    end
    ctrl.pcs  = (rd == 4'hF) & ctrl.reg_w;
    ctrl.cond = instr[31:28];
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Decode pipeline stage: handshake FSM, multiply occupancy counter and the
// registered control bundle presented to execute.
module decode_ctrl_pipe
  import decode_ctrl_pipe_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned EN_MUL  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ImmSrc,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        RegW,
  output logic        MemW,
  output logic        Branch,
  output logic        Link,
  output logic        PCS,
  output logic [1:0]  FlagW,
  output logic [2:0]  ALUControl,
  output logic        Mul,
  output logic        Illegal,
  output logic [3:0]  Cond
);

  localparam logic [3:0] LatLoad = 4'(MUL_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       valid_q, valid_d;
  ctrl_t      ctrl_q, ctrl_d;
  ctrl_t      dec;
  logic       accept;

  decode_ctrl_comb #(
    .EN_MUL(EN_MUL)
  ) u_comb (
    .instr(instr),
    .ctrl (dec)
  );

  assign in_ready = reset & ~flush &
                    ((state_q == StEmpty) | ((state_q == StHold) & out_ready));
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      state_d = StEmpty;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else if (accept) begin
      ctrl_d = dec;
      if (dec.mul && (MUL_LAT > 1)) begin
        state_d = StMulw;
        cnt_d   = LatLoad;
        valid_d = 1'b0;
      end else begin
        state_d = StHold;
        cnt_d   = '0;
        valid_d = 1'b1;
      end
    end else begin
      case (state_q)
        StMulw: begin
          // The bundle is already loaded; it becomes visible when the count expires.
          if (cnt_q <= 4'd1) begin
            state_d = StHold;
            cnt_d   = '0;
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        StHold: begin
          if (out_ready) begin
            state_d = StEmpty;
            valid_d = 1'b0;
          end
        end
        StEmpty: ;
        default: begin
          state_d = StEmpty;
          cnt_d   = '0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StEmpty;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign out_valid  = valid_q;
  assign RegSrc     = ctrl_q.reg_src;
  assign ImmSrc     = ctrl_q.imm_src;
  assign ALUSrc     = ctrl_q.alu_src;
  assign MemtoReg   = ctrl_q.mem_to_reg;
  assign RegW       = ctrl_q.reg_w;
  assign MemW       = ctrl_q.mem_w;
  assign Branch     = ctrl_q.branch;
  assign Link       = ctrl_q.link;
  assign PCS        = ctrl_q.pcs;
  assign FlagW      = ctrl_q.flag_w;
  assign ALUControl = ctrl_q.alu_ctrl;
  assign Mul        = ctrl_q.mul;
  assign Illegal    = ctrl_q.illegal;
  assign Cond       = ctrl_q.cond;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Bench for decode_ctrl_pipe: three parameterisations driven by one stimulus
// stream, checked against a table-driven behavioural model.
module tb_decode_ctrl_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] instr;

  logic [21:0] bun [3];
  logic [2:0]  rdy, vld;

  int n_chk = 0;
  int n_err = 0;

  int unsigned lat_of [3] = '{3, 1, 2};
  bit          en_of  [3] = '{1'b1, 1'b1, 1'b0};

  // Model: cycles left before a multiply result shows, valid flag, held bundle.
  int          m_wait  [3];
  bit          m_valid [3];
  logic [21:0] m_bun   [3];
  bit          m_clean [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned Lat = (g == 0) ? 3 : ((g == 1) ? 1 : 2);
    localparam int unsigned En  = (g == 2) ? 0 : 1;
    logic [1:0] reg_src, imm_src, flag_w;
    logic       alu_src, mem_to_reg, reg_w, mem_w, branch, link, pcs, mul, illegal;
    logic [2:0] alu;
    logic [3:0] cond;

    decode_ctrl_pipe #(
      .MUL_LAT(Lat),
      .EN_MUL (En)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (rdy[g]),
      .instr     (instr),
      .out_valid (vld[g]),
      .out_ready (out_ready),
      .RegSrc    (reg_src),
      .ImmSrc    (imm_src),
      .ALUSrc    (alu_src),
      .MemtoReg  (mem_to_reg),
      .RegW      (reg_w),
      .MemW      (mem_w),
      .Branch    (branch),
      .Link      (link),
      .PCS       (pcs),
      .FlagW     (flag_w),
      .ALUControl(alu),
      .Mul       (mul),
      .Illegal   (illegal),
      .Cond      (cond)
    );

    assign bun[g] = {reg_src, imm_src, alu_src, mem_to_reg, reg_w, mem_w, branch, link, pcs,
                     flag_w, alu, mul, illegal, cond};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Bundle layout: {RegSrc,ImmSrc,ALUSrc,MemtoReg,RegW,MemW,Branch,Link,PCS,FlagW,ALU,Mul,Ill,Cond}
  function automatic logic [21:0] ref_decode(input logic [31:0] w, input bit en);
    logic [1:0] op, rs, is, fw;
    logic [5:0] f;
    logic [2:0] alu;
    logic       as, m2r, rw, mw, br, lk, mu, ill, pcs;
    op = w[27:26];
    f  = w[25:20];
    rs = 2'b00; is = 2'b00; fw = 2'b00; alu = 3'b000;
    as = 1'b0; m2r = 1'b0; rw = 1'b0; mw = 1'b0; br = 1'b0; lk = 1'b0; mu = 1'b0; ill = 1'b0;
    if (op == 2'b00 && f[5:1] == 5'b00000 && w[7:4] == 4'b1001) begin
      if (en) begin
        rw = 1'b1; mu = 1'b1; fw = {f[0], 1'b0};
      end else begin
        ill = 1'b1;
      end
    end else if (op == 2'b00) begin
      case (f[4:1])
        4'b0100: alu = 3'd0;
        4'b0010: alu = 3'd1;
        4'b0000: alu = 3'd2;
        4'b1100: alu = 3'd3;
        4'b1101: alu = 3'd4;
        4'b0001: alu = 3'd5;
        default: ill = 1'b1;
      endcase
      as = f[5];
      rw = 1'b1;
      fw = {f[0], f[0] && (alu <= 3'd1)};
    end else if (op == 2'b01) begin
      is = 2'b01; as = 1'b1; m2r = 1'b1;
      if (f[0]) rw = 1'b1;
      else begin rs = 2'b10; mw = 1'b1; end
    end else if (op == 2'b10) begin
      rs = 2'b01; is = 2'b10; as = 1'b1; br = 1'b1;
      if (f[4]) begin rw = 1'b1; lk = 1'b1; end
    end else begin
      ill = 1'b1;
    end
    if (ill) begin
      rs = 2'b00; is = 2'b00; fw = 2'b00; alu = 3'b000;
      as = 1'b0; m2r = 1'b0; rw = 1'b0; mw = 1'b0; br = 1'b0; lk = 1'b0; mu = 1'b0;
    end
    pcs = (w[15:12] == 4'hF) && rw;
    return {rs, is, as, m2r, rw, mw, br, lk, pcs, fw, alu, mu, ill, w[31:28]};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 2: begin
        w[27:26] = 2'b00;
        if ($urandom_range(0, 3) != 0) begin
          case ($urandom_range(0, 5))
            0:       w[24:21] = 4'b0100;
            1:       w[24:21] = 4'b0010;
            2:       w[24:21] = 4'b0000;
            3:       w[24:21] = 4'b1100;
            4:       w[24:21] = 4'b1101;
            default: w[24:21] = 4'b0001;
          endcase
        end
      end
      3, 4: w[27:26] = 2'b01;
      5, 6: w[27:26] = 2'b10;
      7:    w[27:26] = 2'b11;
      8: begin
        w[27:20] = 8'h00;
        w[7:4]   = 4'b1001;
      end
      default: ;
    endcase
    if ($urandom_range(0, 3) == 0) w[15:12] = 4'hF;
    // Keep multiplies non-flag-setting.
    if (w[27:21] == 7'd0 && w[7:4] == 4'b1001) w[20] = 1'b0;
    return w;
  endfunction

  // One clock: check registered outputs, drive inputs, check in_ready, advance model.
  task automatic step(input bit rn, input bit v, input logic [31:0] ins, input bit fl,
                      input bit ordy);
    bit exp_rdy [3];
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("out_valid[%0d]", k), 32'(vld[k]), 32'(m_valid[k]));
      if (m_valid[k] || m_clean[k])
        check_eq($sformatf("bundle[%0d]", k), 32'(bun[k]), 32'(m_bun[k]));
    end
    reset = rn; in_valid = v; instr = ins; flush = fl; out_ready = ordy;
    #1;
    for (int k = 0; k < 3; k++) begin
      exp_rdy[k] = rn && !fl && (m_wait[k] == 0) && (!m_valid[k] || ordy);
      check_eq($sformatf("in_ready[%0d]", k), 32'(rdy[k]), 32'(exp_rdy[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (!rn) begin
        m_valid[k] = 1'b0; m_wait[k] = 0; m_bun[k] = '0; m_clean[k] = 1'b1;
      end else if (fl) begin
        m_valid[k] = 1'b0; m_wait[k] = 0;
      end else if (v && exp_rdy[k]) begin
        m_bun[k]   = ref_decode(ins, en_of[k]);
        m_clean[k] = 1'b0;
        if (m_bun[k][5] && lat_of[k] > 1) begin
          m_wait[k] = int'(lat_of[k]) - 1; m_valid[k] = 1'b0;
        end else begin
          m_valid[k] = 1'b1;
        end
      end else if (m_wait[k] > 0) begin
        m_wait[k]--;
        if (m_wait[k] == 0) m_valid[k] = 1'b1;
      end else if (m_valid[k] && ordy) begin
        m_valid[k] = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  localparam logic [31:0] Adds = 32'hE0911002;
  localparam logic [31:0] Ldr  = 32'hE591F000;
  localparam logic [31:0] Mulw = 32'hE0010392;

  logic [31:0] stream [4] = '{32'hE0812003, 32'hE0523001, 32'hE3833001, 32'hE0224003};
  logic [2:0]  stream_alu [4] = '{3'd0, 3'd1, 3'd3, 3'd5};

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1; instr = Adds;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      m_valid[k] = 1'b0; m_wait[k] = 0; m_bun[k] = '0; m_clean[k] = 1'b1;
    end
    check_eq("rst_bundle", 32'(bun[0]), 32'd0);
    check_eq("rst_in_ready", 32'(rdy), 32'd0);
    step(1'b0, 1'b1, Adds, 1'b0, 1'b1);

    // ADDS r1: result one cycle after accept.
    step(1'b1, 1'b1, Adds, 1'b0, 1'b1);
    check_eq("adds_valid", 32'(vld[0]), 32'd1);
    check_eq("adds_alu", 32'(bun[0][8:6]), 32'd0);
    check_eq("adds_flagw", 32'(bun[0][10:9]), 32'd3);
    check_eq("adds_regw", 32'(bun[0][15]), 32'd1);
    check_eq("adds_pcs", 32'(bun[0][11]), 32'd0);

    // LDR pc, then stall downstream for three cycles.
    step(1'b1, 1'b1, Ldr, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, Adds, 1'b0, 1'b0);
    check_eq("ldr_memtoreg", 32'(bun[0][16]), 32'd1);
    check_eq("ldr_immsrc", 32'(bun[0][19:18]), 32'd1);
    check_eq("ldr_pcs", 32'(bun[0][11]), 32'd1);
    check_eq("ldr_stall_ready", 32'(rdy[0]), 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);

    // MUL: occupancy differs per instance.
    step(1'b1, 1'b1, Mulw, 1'b0, 1'b1);
    check_eq("mul_c1_valid", 32'(vld[0]), 32'd0);
    check_eq("mul_lat1_mul", 32'(bun[1][5]), 32'd1);
    check_eq("nomul_illegal", 32'(bun[2][4]), 32'd1);
    check_eq("nomul_regw", 32'(bun[2][15]), 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    check_eq("mul_c2_ready", 32'(rdy[0]), 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    check_eq("mul_c3_valid", 32'(vld[0]), 32'd1);
    check_eq("mul_c3_mul", 32'(bun[0][5]), 32'd1);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);

    // Flush in the cycle after a MUL accept, with a competing in_valid.
    step(1'b1, 1'b1, Mulw, 1'b0, 1'b1);
    step(1'b1, 1'b1, Adds, 1'b1, 1'b1);
    check_eq("flush_c2_valid", 32'(vld), 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    check_eq("flush_c3_valid", 32'(vld[0]), 32'd0);

    // Reset while a multiply is pending.
    step(1'b1, 1'b1, Mulw, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    check_eq("mulrst_valid", 32'(vld[0]), 32'd0);

    // Back-to-back DP stream, then an Op=11 word.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, stream[i], 1'b0, 1'b1);
      check_eq($sformatf("stream%0d_valid", i), 32'(vld[0]), 32'd1);
      check_eq($sformatf("stream%0d_alu", i), 32'(bun[0][8:6]), 32'(stream_alu[i]));
    end
    step(1'b1, 1'b1, 32'hEE012003, 1'b0, 1'b1);
    check_eq("op11_illegal", 32'(bun[0][4]), 32'd1);
    check_eq("op11_wmb", 32'(bun[0][15:13]), 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);

    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) < 7), rand_instr(),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7));
    end
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
